wb_arbiter2: RTL and testbench

- Two-master, one-slave Wishbone arbiter that shares a single Wishbone slave (the on-chip BlockRAM) between two masters, e.g. the LM32 instruction bus (m0) and data bus (m1).
- Round-robin grant, locked for the whole of the granted master's cycle (cyc high).
- Per-transfer watchdog: a stalled slave cannot hang the CPU; the granted master receives a one-cycle error pulse instead.

---
 rtl/wb_arbiter2_pkg.sv | 15 +
 rtl/wb_arbiter2_if.sv | 25 ++
 rtl/wb_arbiter2_watchdog.sv | 53 +++++
 rtl/wb_arbiter2.sv | 104 ++++++++++
 tb/tb_wb_arbiter2.sv | 219 +++++++++++++++++++++
 5 files changed

// File: rtl/wb_arbiter2_pkg.sv
// Shared constants and types for the two-master Wishbone arbiter.
package wb_arbiter2_pkg;

    localparam int unsigned ADR_W = 32;
    localparam int unsigned DAT_W = 32;
    localparam int unsigned SEL_W = 4;

    // Grant state: idle, or bus owned by master 0 / master 1.
    typedef enum logic [1:0] {
        StIdle = 2'b00,
        StG0   = 2'b01,
        StG1   = 2'b10
    } state_e;

endpackage

// File: rtl/wb_arbiter2_if.sv
// One Wishbone link. "master" is the side that issues cycles, "slave" answers them.
interface wb_arbiter2_if;
    import wb_arbiter2_pkg::*;

    logic [ADR_W-1:0] adr;
    logic [DAT_W-1:0] dat_m;  // master -> slave write data
    logic [DAT_W-1:0] dat_s;  // slave -> master read data
    logic [SEL_W-1:0] sel;
    logic             we;
    logic             stb;
    logic             cyc;
    logic             ack;
    logic             err;

    modport master (
        output adr, dat_m, sel, we, stb, cyc,
        input  dat_s, ack, err
    );

    modport slave (
        input  adr, dat_m, sel, we, stb, cyc,
        output dat_s, ack, err
    );

endinterface

// File: rtl/wb_arbiter2_watchdog.sv
// Per-transfer watchdog: counts cycles a strobe waits for ack and emits a
// one-cycle error pulse when the wait exceeds the budget. TIMEOUT=0 disables it.
module wb_arbiter2_watchdog #(
    parameter int unsigned TIMEOUT = 255,
    parameter int unsigned CNT_W   = 8
) (
    input  logic clk_i,
    input  logic rst_n_i,
    input  logic cyc_i,
    input  logic stb_i,
    input  logic ack_i,
    input  logic clr_i,
    output logic err_o
);

    localparam logic [CNT_W-1:0] Limit  = CNT_W'(TIMEOUT);
    localparam bit               Enable = (TIMEOUT != 0);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             err_q, err_d;
    logic             stall;

    // A stall cycle is a live strobe without ack; an ack in the limit cycle wins.
    assign stall = cyc_i & stb_i & ~ack_i;

    // Next count: anything but a continuing stall clears it; the error pulse
    // lands the cycle after the counter sits at the limit.
    always_comb begin
        cnt_d = '0;
        err_d = 1'b0;
        if (Enable && !clr_i && stall) begin
            if (cnt_q == Limit) begin
                err_d = 1'b1;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    // Counter and pulse registers.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            cnt_q <= '0;
            err_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            err_q <= err_d;
        end
    end

    assign err_o = err_q;

endmodule

// File: rtl/wb_arbiter2.sv
// Two-master, one-slave Wishbone arbiter: round-robin on ties, grant locked
// while the owner holds cyc, watchdog error instead of hanging on a dead slave.
module wb_arbiter2
    import wb_arbiter2_pkg::*;
#(
    parameter int unsigned TIMEOUT = 255,
    parameter int unsigned CNT_W   = 8
) (
    input  logic           clk_i,
    input  logic           rst_n_i,
    wb_arbiter2_if.slave   m0_bus,
    wb_arbiter2_if.slave   m1_bus,
    wb_arbiter2_if.master  s_bus
);

    state_e state_q, state_d;
    logic   last_q, last_d;
    logic   grant_chg;
    logic   wd_err;

    // Grant FSM next state; last records the most recent owner for tie-breaks.
    always_comb begin
        state_d = state_q;
        last_d  = last_q;
        unique case (state_q)
            StIdle: begin
                if (m0_bus.cyc && m1_bus.cyc) state_d = last_q ? StG0 : StG1;
                else if (m0_bus.cyc)          state_d = StG0;
                else if (m1_bus.cyc)          state_d = StG1;
            end
            StG0: if (!m0_bus.cyc) state_d = m1_bus.cyc ? StG1 : StIdle;
            StG1: if (!m1_bus.cyc) state_d = m0_bus.cyc ? StG0 : StIdle;
            default: state_d = StIdle;
        endcase
        if (state_d == StG0 && state_q != StG0) last_d = 1'b0;
        if (state_d == StG1 && state_q != StG1) last_d = 1'b1;
    end

    assign grant_chg = (state_d != state_q);

    // Grant register; reset makes m0 the winner of the first tie.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q <= StIdle;
            last_q  <= 1'b1;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
        end
    end

    // Bus mux from the registered grant; the strobe is withheld in the error cycle.
    always_comb begin
        s_bus.adr    = '0;
        s_bus.dat_m  = '0;
        s_bus.sel    = '0;
        s_bus.we     = 1'b0;
        s_bus.stb    = 1'b0;
        s_bus.cyc    = 1'b0;
        m0_bus.dat_s = s_bus.dat_s;
        m1_bus.dat_s = s_bus.dat_s;
        m0_bus.ack   = 1'b0;
        m0_bus.err   = 1'b0;
        m1_bus.ack   = 1'b0;
        m1_bus.err   = 1'b0;
        unique case (state_q)
            StG0: begin
                s_bus.adr   = m0_bus.adr;
                s_bus.dat_m = m0_bus.dat_m;
                s_bus.sel   = m0_bus.sel;
                s_bus.we    = m0_bus.we;
                s_bus.stb   = m0_bus.stb & ~wd_err;
                s_bus.cyc   = m0_bus.cyc;
                m0_bus.ack  = s_bus.ack & m0_bus.stb & ~wd_err;
                m0_bus.err  = wd_err;
            end
            StG1: begin
                s_bus.adr   = m1_bus.adr;
                s_bus.dat_m = m1_bus.dat_m;
                s_bus.sel   = m1_bus.sel;
                s_bus.we    = m1_bus.we;
                s_bus.stb   = m1_bus.stb & ~wd_err;
                s_bus.cyc   = m1_bus.cyc;
                m1_bus.ack  = s_bus.ack & m1_bus.stb & ~wd_err;
                m1_bus.err  = wd_err;
            end
            default: ;
        endcase
    end

    wb_arbiter2_watchdog #(
        .TIMEOUT (TIMEOUT),
        .CNT_W   (CNT_W)
    ) u_watchdog (
        .clk_i   (clk_i),
        .rst_n_i (rst_n_i),
        .cyc_i   (s_bus.cyc),
        .stb_i   (s_bus.stb),
        .ack_i   (s_bus.ack),
        .clr_i   (grant_chg),
        .err_o   (wd_err)
    );

endmodule

// File: tb/tb_wb_arbiter2.sv
// Directed bench for wb_arbiter2 with a 4-cycle watchdog budget.
module tb_wb_arbiter2;
    import wb_arbiter2_pkg::*;

    logic clk = 1'b0;
    logic rst_n;
    int   total = 0;
    int   bad   = 0;

    wb_arbiter2_if m0_bus ();
    wb_arbiter2_if m1_bus ();
    wb_arbiter2_if s_bus ();

    wb_arbiter2 #(
        .TIMEOUT (4),
        .CNT_W   (3)
    ) dut (
        .clk_i   (clk),
        .rst_n_i (rst_n),
        .m0_bus  (m0_bus),
        .m1_bus  (m1_bus),
        .s_bus   (s_bus)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        m0_bus.cyc = 1'b0; m0_bus.stb = 1'b0; m0_bus.we = 1'b0;
        m1_bus.cyc = 1'b0; m1_bus.stb = 1'b0; m1_bus.we = 1'b0;
        s_bus.ack  = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        m0_bus.adr = 32'h0; m0_bus.dat_m = 32'h0; m0_bus.sel = 4'h0;
        m1_bus.adr = 32'h0; m1_bus.dat_m = 32'h0; m1_bus.sel = 4'h0;
        s_bus.dat_s = 32'h0; s_bus.err = 1'b0;
        idle_inputs();
        m0_bus.cyc = 1'b1; m0_bus.stb = 1'b1; s_bus.ack = 1'b1;
        #2;
        total++; if (s_bus.cyc !== 1'b0) begin bad++; $display("FAIL reset_s_cyc got=%b want=0", s_bus.cyc); end
        total++; if (s_bus.stb !== 1'b0) begin bad++; $display("FAIL reset_s_stb got=%b want=0", s_bus.stb); end
        total++; if (m0_bus.ack !== 1'b0) begin bad++; $display("FAIL reset_m0_ack got=%b want=0", m0_bus.ack); end
        total++; if (m0_bus.err !== 1'b0) begin bad++; $display("FAIL reset_m0_err got=%b want=0", m0_bus.err); end
        total++; if (m1_bus.ack !== 1'b0) begin bad++; $display("FAIL reset_m1_ack got=%b want=0", m1_bus.ack); end
        idle_inputs();
        step();
        rst_n = 1'b1;
    endtask

    task automatic test_single();
        step();
        m0_bus.cyc = 1'b1; m0_bus.stb = 1'b1; m0_bus.adr = 32'h0000_0010;
        m0_bus.sel = 4'hF; m0_bus.we = 1'b0;
        #1;
        total++; if (s_bus.cyc !== 1'b0) begin bad++; $display("FAIL single_latency got=%b want=0", s_bus.cyc); end
        step();
        total++; if (s_bus.cyc !== 1'b1) begin bad++; $display("FAIL single_s_cyc got=%b want=1", s_bus.cyc); end
        total++; if (s_bus.stb !== 1'b1) begin bad++; $display("FAIL single_s_stb got=%b want=1", s_bus.stb); end
        total++; if (s_bus.adr !== 32'h10) begin bad++; $display("FAIL single_s_adr got=%h want=10", s_bus.adr); end
        total++; if (m0_bus.ack !== 1'b0) begin bad++; $display("FAIL single_ack_early got=%b want=0", m0_bus.ack); end
        s_bus.ack = 1'b1; s_bus.dat_s = 32'hDEAD_BEEF;
        #1;
        total++; if (m0_bus.ack !== 1'b1) begin bad++; $display("FAIL single_m0_ack got=%b want=1", m0_bus.ack); end
        total++; if (m0_bus.dat_s !== 32'hDEAD_BEEF) begin bad++; $display("FAIL single_m0_dat got=%h want=deadbeef", m0_bus.dat_s); end
        total++; if (m1_bus.ack !== 1'b0) begin bad++; $display("FAIL single_m1_ack got=%b want=0", m1_bus.ack); end
        total++; if (m1_bus.err !== 1'b0) begin bad++; $display("FAIL single_m1_err got=%b want=0", m1_bus.err); end
        step();
        idle_inputs();
        step();
        total++; if (s_bus.cyc !== 1'b0) begin bad++; $display("FAIL single_release got=%b want=0", s_bus.cyc); end
    endtask

    task automatic test_tie();
        logic [31:0] exp_adr;
        logic        exp_m0;
        rst_n = 1'b0;
        #1;
        rst_n = 1'b1;
        m0_bus.adr = 32'h100; m1_bus.adr = 32'h200;
        for (int r = 0; r < 3; r++) begin
            exp_adr = (r == 1) ? 32'h200 : 32'h100;
            exp_m0  = (r != 1);
            step();
            m0_bus.cyc = 1'b1; m0_bus.stb = 1'b1;
            m1_bus.cyc = 1'b1; m1_bus.stb = 1'b1;
            step();
            total++; if (s_bus.adr !== exp_adr) begin bad++; $display("FAIL tie_grant_%0d got=%h want=%h", r, s_bus.adr, exp_adr); end
            s_bus.ack = 1'b1;
            #1;
            total++; if (m0_bus.ack !== exp_m0) begin bad++; $display("FAIL tie_m0_ack_%0d got=%b want=%b", r, m0_bus.ack, exp_m0); end
            total++; if (m1_bus.ack !== !exp_m0) begin bad++; $display("FAIL tie_m1_ack_%0d got=%b want=%b", r, m1_bus.ack, !exp_m0); end
            step();
            idle_inputs();
            step();
        end
    endtask

    task automatic test_lock();
        step();
        m1_bus.cyc = 1'b1; m1_bus.stb = 1'b1; m1_bus.we = 1'b1; m1_bus.sel = 4'hF;
        m1_bus.adr = 32'h0; m1_bus.dat_m = 32'h1000;
        m0_bus.cyc = 1'b1; m0_bus.stb = 1'b1; m0_bus.we = 1'b0; m0_bus.sel = 4'h3;
        m0_bus.adr = 32'h40;
        for (int i = 0; i < 4; i++) begin
            step();
            m1_bus.adr = 32'(i * 4); m1_bus.dat_m = 32'h1000 + 32'(i);
            s_bus.ack = 1'b1;
            #1;
            total++; if (s_bus.adr !== 32'(i * 4)) begin bad++; $display("FAIL lock_adr_%0d got=%h want=%h", i, s_bus.adr, i * 4); end
            total++; if (s_bus.dat_m !== 32'h1000 + 32'(i)) begin bad++; $display("FAIL lock_dat_%0d got=%h want=%h", i, s_bus.dat_m, 32'h1000 + i); end
            total++; if (s_bus.we !== 1'b1 || s_bus.sel !== 4'hF) begin bad++; $display("FAIL lock_ctl_%0d got=%b/%h want=1/f", i, s_bus.we, s_bus.sel); end
            total++; if (m1_bus.ack !== 1'b1) begin bad++; $display("FAIL lock_m1_ack_%0d got=%b want=1", i, m1_bus.ack); end
            total++; if (m0_bus.ack !== 1'b0) begin bad++; $display("FAIL lock_m0_ack_%0d got=%b want=0", i, m0_bus.ack); end
        end
        step();
        m1_bus.cyc = 1'b0; m1_bus.stb = 1'b0; m1_bus.we = 1'b0; s_bus.ack = 1'b0;
        #1;
        total++; if (s_bus.cyc !== 1'b0) begin bad++; $display("FAIL lock_drop_cyc got=%b want=0", s_bus.cyc); end
        step();
        total++; if (s_bus.cyc !== 1'b1) begin bad++; $display("FAIL lock_handoff_cyc got=%b want=1", s_bus.cyc); end
        total++; if (s_bus.adr !== 32'h40 || s_bus.sel !== 4'h3) begin bad++; $display("FAIL lock_handoff_adr got=%h/%h want=40/3", s_bus.adr, s_bus.sel); end
        s_bus.ack = 1'b1;
        #1;
        total++; if (m0_bus.ack !== 1'b1) begin bad++; $display("FAIL lock_m0_served got=%b want=1", m0_bus.ack); end
        step();
        idle_inputs();
        step();
    endtask

    task automatic test_timeout();
        logic exp_err;
        step();
        m0_bus.cyc = 1'b1; m0_bus.stb = 1'b1; m0_bus.adr = 32'h80;
        for (int n = 0; n < 6; n++) begin
            exp_err = (n == 5);
            step();
            total++; if (m0_bus.err !== exp_err) begin bad++; $display("FAIL timeout_err_%0d got=%b want=%b", n, m0_bus.err, exp_err); end
            total++; if (s_bus.stb !== !exp_err) begin bad++; $display("FAIL timeout_stb_%0d got=%b want=%b", n, s_bus.stb, !exp_err); end
            total++; if (m0_bus.ack !== 1'b0) begin bad++; $display("FAIL timeout_ack_%0d got=%b want=0", n, m0_bus.ack); end
        end
        total++; if (m1_bus.err !== 1'b0) begin bad++; $display("FAIL timeout_m1_err got=%b want=0", m1_bus.err); end
        idle_inputs();
        step();
        total++; if (m0_bus.err !== 1'b0) begin bad++; $display("FAIL timeout_single_pulse got=%b want=0", m0_bus.err); end
        step();
    endtask

    task automatic test_collision();
        step();
        m0_bus.cyc = 1'b1; m0_bus.stb = 1'b1; m0_bus.adr = 32'h84;
        for (int n = 0; n < 4; n++) begin
            step();
            total++; if (m0_bus.err !== 1'b0) begin bad++; $display("FAIL coll_wait_err_%0d got=%b want=0", n, m0_bus.err); end
        end
        step();
        s_bus.ack = 1'b1;
        #1;
        total++; if (m0_bus.ack !== 1'b1) begin bad++; $display("FAIL coll_ack got=%b want=1", m0_bus.ack); end
        total++; if (m0_bus.err !== 1'b0) begin bad++; $display("FAIL coll_err got=%b want=0", m0_bus.err); end
        step();
        idle_inputs();
        total++; if (m0_bus.err !== 1'b0) begin bad++; $display("FAIL coll_err_after got=%b want=0", m0_bus.err); end
        step();
    endtask

    task automatic test_async_reset();
        step();
        m1_bus.cyc = 1'b1; m1_bus.stb = 1'b1; m1_bus.adr = 32'h300;
        step();
        s_bus.ack = 1'b1;
        #1;
        total++; if (s_bus.cyc !== 1'b1 || m1_bus.ack !== 1'b1) begin bad++; $display("FAIL arst_pre got=%b/%b want=1/1", s_bus.cyc, m1_bus.ack); end
        #1;
        rst_n = 1'b0;
        #1;
        total++; if (s_bus.cyc !== 1'b0) begin bad++; $display("FAIL arst_s_cyc got=%b want=0", s_bus.cyc); end
        total++; if (s_bus.stb !== 1'b0) begin bad++; $display("FAIL arst_s_stb got=%b want=0", s_bus.stb); end
        total++; if (m1_bus.ack !== 1'b0) begin bad++; $display("FAIL arst_m1_ack got=%b want=0", m1_bus.ack); end
        total++; if (m1_bus.err !== 1'b0) begin bad++; $display("FAIL arst_m1_err got=%b want=0", m1_bus.err); end
        idle_inputs();
        step();
        step();
        rst_n = 1'b1;
        step();
        m0_bus.adr = 32'h500; m1_bus.adr = 32'h600;
        m0_bus.cyc = 1'b1; m0_bus.stb = 1'b1;
        m1_bus.cyc = 1'b1; m1_bus.stb = 1'b1;
        step();
        total++; if (s_bus.adr !== 32'h500 || s_bus.cyc !== 1'b1) begin bad++; $display("FAIL arst_first_tie got=%h/%b want=500/1", s_bus.adr, s_bus.cyc); end
        idle_inputs();
        step();
        step();
    endtask

    initial begin
        test_reset();
        test_single();
        test_tie();
        test_lock();
        test_timeout();
        test_collision();
        test_async_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL time_limit got=running want=finished");
        $fatal(1, "simulation time limit reached");
    end

endmodule
